// File: rtl/sseg_pkg.sv
// Shared types, segment glyphs and the anode decode helper for the 7-segment scan controller.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_T     = 7'b0000111;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_N     = 7'b0101011;
    localparam seg_t SEG_R     = 7'b0101111;

    function automatic logic [7:0] onehot_an(input logic [2:0] idx, input int n);
        logic [7:0] an;
        for (int i = 0; i < 8; i++) begin
            an[i] = !((i < n) && (i == int'(idx)));
        end
        return an;
    endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// Slot divider and digit index counter; frame_tick pulses once as the index wraps to 0.
module sseg_refresh_timer #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             frame_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_tick_q, frame_tick_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (slot_end) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d        = '0;
                frame_tick_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign cnt        = cnt_q;
    assign idx        = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with guard blanking and override message.
// Optional macro SSEG_BLINK_EN builds the per-digit blink phase logic.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int   NUM_DIGITS   = 4,
    parameter int   REFRESH_DIV  = 100000,
    parameter int   GUARD_CYCLES = 2,
    parameter seg_t OVR_CHAR     = SEG_T,
    parameter int   BLINK_FRAMES = 64,
    localparam int  IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int  CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [6:0]            wr_char,
    input  logic                  override,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic [6:0]            char_out,
    output logic                  frame_tick
);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    seg_t                  char_q [NUM_DIGITS];
    seg_t                  char_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  out_char_q, out_char_d;
    logic                  blink_off;
    logic                  wr_hit;

    sseg_refresh_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .idx       (idx),
        .frame_tick(frame_tick)
    );

    assign wr_hit = wr_en && (int'(wr_idx) < NUM_DIGITS);

    // char_d doubles as a write bypass so a write to the shown digit lands on the very next edge
    always_comb begin
        char_d = char_q;
        if (wr_hit) begin
            char_d[wr_idx] = wr_char;
        end
    end

`ifdef SSEG_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;

    always_comb begin
        frm_d   = frm_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (frm_q == '0) begin
                frm_d   = FRM_W'(BLINK_FRAMES - 1);
                phase_d = !phase_q;
            end else begin
                frm_d = frm_q - FRM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q   <= FRM_W'(BLINK_FRAMES - 1);
            phase_q <= 1'b1;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = !phase_q;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_off         = 1'b0;
`endif

    always_comb begin
        an_d       = '1;
        out_char_d = SEG_BLANK;
        if (int'(cnt) >= GUARD_CYCLES) begin
            an_d = NUM_DIGITS'(onehot_an(3'(idx), NUM_DIGITS));
            if (override) begin
                out_char_d = (idx == IDX_W'(NUM_DIGITS - 1)) ? OVR_CHAR : SEG_BLANK;
            end else if (blink_off && blink_mask[idx]) begin
                out_char_d = SEG_BLANK;
            end else begin
                out_char_d = char_d[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q       <= '1;
            out_char_q <= SEG_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                char_q[i] <= SEG_BLANK;
            end
        end else begin
            an_q       <= an_d;
            out_char_q <= out_char_d;
            char_q     <= char_d;
        end
    end

    assign an_out   = an_q;
    assign char_out = out_char_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: 4-digit and 3-digit instances against a time-indexed reference model.
module tb_sseg_scan_ctrl;

    localparam int R  = 8;
    localparam int G  = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [6:0] wr_char;
    logic       override;
    logic [3:0] blink_mask;

    logic [3:0] an4;
    logic [6:0] ch4;
    logic       ft4;
    logic [2:0] an3;
    logic [6:0] ch3;
    logic       ft3;

    int pass_cnt = 0;
    int total    = 0;
    int t        = 0;
    int ft_seen  = 0;

    logic [6:0] mchar  [2][4];
    logic [3:0] exp_an [2];
    logic [6:0] exp_ch [2];
    logic       exp_ft [2];

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS(4), .REFRESH_DIV(R), .GUARD_CYCLES(G),
        .OVR_CHAR(7'b0000111), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .override(override), .blink_mask(blink_mask),
        .an_out(an4), .char_out(ch4), .frame_tick(ft4)
    );

    sseg_scan_ctrl #(
        .NUM_DIGITS(3), .REFRESH_DIV(R), .GUARD_CYCLES(G),
        .OVR_CHAR(7'b0000111), .BLINK_FRAMES(BF)
    ) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .override(override), .blink_mask(blink_mask[2:0]),
        .an_out(an3), .char_out(ch3), .frame_tick(ft3)
    );

    // Blink phase at timer state s: frames completed before s, grouped by BF
    function automatic bit blink_off(int s, int n);
`ifdef SSEG_BLINK_EN
        int frames;
        frames = (s >= 1) ? (s - 1) / (R * n) : 0;
        return ((frames / BF) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int n, s, cnt, idx;
            n = (k == 0) ? 4 : 3;
            if (rst) begin
                for (int i = 0; i < 4; i++) mchar[k][i] = 7'h7F;
                exp_an[k] = 4'hF;
                exp_ch[k] = 7'h7F;
                exp_ft[k] = 1'b0;
            end else begin
                s   = t;
                cnt = s % R;
                idx = (s / R) % n;
                if (wr_en && int'(wr_idx) < n) mchar[k][wr_idx] = wr_char;
                if (cnt < G) begin
                    exp_an[k] = 4'hF;
                    exp_ch[k] = 7'h7F;
                end else begin
                    exp_an[k] = ~(4'b0001 << idx);
                    if (override)
                        exp_ch[k] = (idx == n - 1) ? 7'h07 : 7'h7F;
                    else if (blink_off(s, n) && blink_mask[idx])
                        exp_ch[k] = 7'h7F;
                    else
                        exp_ch[k] = mchar[k][idx];
                end
                exp_ft[k] = ((s + 1) % (R * n)) == 0;
            end
        end
        t = rst ? 0 : t + 1;
    endtask

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] expv);
        total++;
        assert (got === expv) pass_cnt++;
        else $error("FAIL %s got=%h expected=%h t=%0d", tag, got, expv, t);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("an4", {3'b0, an4}, {3'b0, exp_an[0]});
        chk("char4", ch4, exp_ch[0]);
        chk("ft4", {6'b0, ft4}, {6'b0, exp_ft[0]});
        chk("an3", {3'b0, 1'b1, an3}, {3'b0, exp_an[1]});
        chk("char3", ch3, exp_ch[1]);
        chk("ft3", {6'b0, ft3}, {6'b0, exp_ft[1]});
        if (ft4) ft_seen++;
    endtask

    task automatic wait_slot(input int c, input int d, input string tag);
        int budget;
        budget = 0;
        while (!((t % R) == c && ((t / R) % 4) == d) && budget < 64) begin
            step();
            budget++;
        end
        total++;
        assert (budget < 64) pass_cnt++;
        else $error("FAIL %s sync timeout got=%0d expected<64", tag, budget);
    endtask

    task automatic write_char(input logic [1:0] i, input logic [6:0] c);
        wr_en   = 1'b1;
        wr_idx  = i;
        wr_char = c;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_char    = '0;
        override   = 1'b0;
        blink_mask = '0;
        step();
        step();
        rst = 1'b0;

        write_char(2'd0, 7'h2F);
        write_char(2'd1, 7'h2B);
        write_char(2'd2, 7'h21);

        ft_seen = 0;
        repeat (96) step();
        total++;
        assert (ft_seen == 3) pass_cnt++;
        else $error("FAIL frame_count got=%0d expected=3", ft_seen);

        override = 1'b1;
        repeat (40) step();
        override = 1'b0;
        repeat (16) step();

        wait_slot(4, 2, "midslot");
        write_char(2'd2, 7'h12);
        write_char(2'd3, 7'h00);
        repeat (40) step();

        wait_slot(5, 1, "rst_mid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        write_char(2'd0, 7'h2F);
        write_char(2'd1, 7'h2B);
        write_char(2'd2, 7'h21);
        write_char(2'd3, 7'h0C);
        blink_mask = 4'b0001;
        repeat (200) step();

        repeat (800) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_idx  = 2'($urandom);
            wr_char = 7'($urandom);
            if ($urandom_range(0, 29) == 0) override = ~override;
            if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scan controller.
- Holds one character register per digit and time-multiplexes the digits onto shared anode and cathode pins.
- Guard-blanks each digit change to prevent ghosting.
- Supports a priority override message on the leftmost digit.
- Sits between the steering/status logic, which writes characters, and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (must be > GUARD_CYCLES + 1).
- GUARD_CYCLES, 2, cycles at the start of each slot with all anodes off (0 disables guard).
- OVR_CHAR, 7'b0000111, pattern shown on digit NUM_DIGITS-1 while override is high ('T').
- BLINK_FRAMES, 64, full frames per blink half-period (used only with SSEG_BLINK_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  character write strobe.
- wr_idx  in  $clog2(NUM_DIGITS)  target digit; 0 = rightmost (an_out[0]).
- wr_char  in  7  active-low segment pattern {g..a}.
- override  in  1  level; forces override display (e.g. backtrack active).
- blink_mask  in  NUM_DIGITS  per-digit blink enable.
- an_out  out  NUM_DIGITS  active-low anodes, at most one bit low.
- char_out  out  7  active-low cathodes.
- frame_tick  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Reset values:
  - char regs = 7'h7F; cnt = 0; idx = 0.
  - an_out = all ones (display dark).
  - char_out = 7'h7F; frame_tick = 0; blink phase = on.
- Slot timer:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the edge where cnt == REFRESH_DIV-1, idx advances by one.
  - idx wraps NUM_DIGITS-1 -> 0. On that wrap edge, frame_tick is registered high for exactly one cycle.
- Output registers:
  - Computed from the current cnt/idx, so they lag the timer by 1 cycle.
  - If cnt < GUARD_CYCLES: an_out <= all ones, char_out <= 7'h7F.
  - Otherwise: an_out <= ~(1 << idx); char_out <= selected pattern.
- Pattern select, in priority order:
  1. override=1 and idx==NUM_DIGITS-1 -> OVR_CHAR.
  2. override=1, any other idx -> 7'h7F (blank).
  3. Blink-off phase and blink_mask[idx] -> 7'h7F.
  4. Otherwise -> char_reg[idx].
- Writes:
  - When wr_en=1 and wr_idx < NUM_DIGITS, char_reg[wr_idx] <= wr_char at that edge.
  - Out-of-range wr_idx is silently ignored.
  - A write to the currently displayed digit appears on char_out on the next edge, with no tearing mid-slot beyond that.
  - Back-to-back writes are allowed every cycle; the last write wins.
- Override:
  - override is sampled every cycle, with no latching.
  - Asserting or deasserting it changes char_out within 1 cycle.
  - Scanning continues unchanged. Character registers are preserved and reappear after deassertion.
- Reset mid-slot: all state returns to reset values at the next edge; the display goes dark for at least 1 cycle.
- Simultaneous write and slot advance: the write commits, and the new idx is used on the following edge.

Optional Feature:
- Macro: SSEG_BLINK_EN.
- Defined:
  - A frame counter counts frame_tick pulses.
  - Every BLINK_FRAMES frames the blink phase toggles.
  - During the off phase, digits with blink_mask set are blanked; override still has priority.
- Undefined:
  - No frame counter or phase logic is built.
  - blink_mask is ignored but remains a port so the interface is unchanged.

Decomposition:
- Package sseg_pkg:
  - typedef seg_t (logic [6:0]).
  - Constants SEG_BLANK=7'h7F, SEG_T, SEG_D, SEG_N, SEG_R.
  - Function onehot_an(idx, n) returning the active-low anode vector.
- Sub-module sseg_refresh_timer:
  - Contains the cnt divider, idx counter and frame_tick generator.
  - Parameters NUM_DIGITS and REFRESH_DIV; outputs cnt, idx, frame_tick.
- Top level holds the char register file, override/blink mux and output registers.

Test Plan (bench params: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2):
1. Reset, then write idx0=7'h2F, idx1=7'h2B, idx2=7'h21 -> an_out cycles 1110, 1101, 1011, 0111 every 8 cycles. Patterns are 2F/2B/21/7F. Each slot starts with 2 cycles of an_out=1111.
2. Run 3 full frames -> frame_tick is high exactly 1 cycle per 32 cycles, aligned one cycle after idx wraps 3->0.
3. Raise override for 40 cycles -> slot 3 shows 7'h07 and slots 0-2 show 7'h7F. Release -> the original patterns return within 1 cycle.
4. wr_en with wr_idx=2 while idx=2 is mid-slot (cnt=4) -> char_out changes on the next edge. wr_idx out of range (NUM_DIGITS=3 build, wr_idx=3) -> no register changes.
5. Assert rst at cnt=5 in slot 1 -> next cycle an_out=1111, char_out=7'h7F. After release, scanning restarts at idx0 and all characters are blank.
6. With SSEG_BLINK_EN, BLINK_FRAMES=2 and blink_mask=4'b0001 -> digit 0 is blanked for 2 frames and shown for 2 frames, alternating. Without the macro, digit 0 is never blanked.
